// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between the CPU-side master and the SRAM responder.
// Latency: none, wires only.
// Backpressure: carries the valid/ready pairs of all five AXI channels unchanged.
// Ports: AR, R, AW, W and B channel signals; the slave modport is for the
// responder and the master modport is for whatever drives requests.
interface axi_sram_slave_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 responder serving read/write bursts from one single-port synchronous SRAM.
// Latency: AR handshake to first rvalid is 3 cycles; each further read beat takes 3 cycles.
// Backpressure: R and B hold until ready; W port yields to nothing, reads stall one cycle per write beat.
// Ports: aclk/reset (sync, active high), axi (slave modport of axi_sram_slave_if),
// ram_en/ram_we/ram_addr/ram_wdata to the SRAM and ram_rdata back (valid one cycle after a read).
module axi_sram_slave #(
    parameter int MEM_AW = 16,
    parameter int ID_W   = 4
) (
    input  logic                aclk,
    input  logic                reset,
    axi_sram_slave_if.slave     axi,
    output logic                ram_en,
    output logic [3:0]          ram_we,
    output logic [MEM_AW-1:0]   ram_addr,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata
);
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_REQ  = 2'd1;
    localparam logic [1:0] R_WAIT = 2'd2;
    localparam logic [1:0] R_DATA = 2'd3;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // read channel state
    logic [1:0]      r_state_q, r_state_d;
    logic [ID_W-1:0] r_id_q,    r_id_d;
    logic [31:0]     r_addr_q,  r_addr_d;
    logic [7:0]      r_len_q,   r_len_d;
    logic [2:0]      r_size_q,  r_size_d;
    logic [1:0]      r_burst_q, r_burst_d;
    logic [7:0]      r_beat_q,  r_beat_d;
    logic            r_oor_q,   r_oor_d;
    logic [31:0]     rdata_q,   rdata_d;
    logic [1:0]      rresp_q,   rresp_d;

    // write channel state
    logic [1:0]      w_state_q, w_state_d;
    logic [ID_W-1:0] w_id_q,    w_id_d;
    logic [31:0]     w_addr_q,  w_addr_d;
    logic [7:0]      w_len_q,   w_len_d;
    logic [2:0]      w_size_q,  w_size_d;
    logic [1:0]      w_burst_q, w_burst_d;
    logic [7:0]      w_beat_q,  w_beat_d;
    logic            w_err_q,   w_err_d;
    logic [1:0]      bresp_q,   bresp_d;

    logic w_gnt, r_gnt, r_oor, w_oor, r_last, w_err_nx;

    // FIXED keeps the address; every other burst code behaves as INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        if (burst == 2'b00) begin
            return addr;
        end
        return addr + (32'd1 << size);
    endfunction

    // A write beat only claims the port when it actually has data, and then
    // it always wins; the pending read simply retries next cycle.
    assign w_gnt  = (w_state_q == W_DATA) && axi.wvalid;
    assign r_gnt  = (r_state_q == R_REQ) && !w_gnt;
    assign r_oor  = |r_addr_q[31:MEM_AW+2];
    assign w_oor  = |w_addr_q[31:MEM_AW+2];
    assign r_last = (r_beat_q == r_len_q);

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_beat_d  = r_beat_q;
        r_oor_d   = r_oor_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        bresp_d   = bresp_q;
        w_err_nx  = w_err_q;
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        ram_addr  = '0;
        ram_wdata = 32'h0;

        case (r_state_q)
            R_IDLE: begin
                if (axi.arvalid) begin
                    r_id_d    = axi.arid;
                    r_addr_d  = axi.araddr;
                    r_len_d   = axi.arlen;
                    r_size_d  = axi.arsize;
                    r_burst_d = axi.arburst;
                    r_beat_d  = 8'd0;
                    r_state_d = R_REQ;
                end
            end
            R_REQ: begin
                if (r_gnt) begin
                    // out-of-range beats skip the SRAM but keep the same timing
                    r_oor_d = r_oor;
                    if (!r_oor) begin
                        ram_en   = 1'b1;
                        ram_addr = r_addr_q[MEM_AW+1:2];
                    end
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                rdata_d   = r_oor_q ? 32'h0 : ram_rdata;
                rresp_d   = r_oor_q ? RESP_SLVERR : RESP_OKAY;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (axi.rready) begin
                    if (r_last) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_beat_d  = r_beat_q + 8'd1;
                        r_addr_d  = next_addr(r_addr_q, r_size_q, r_burst_q);
                        r_state_d = R_REQ;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        case (w_state_q)
            W_IDLE: begin
                if (axi.awvalid) begin
                    w_id_d    = axi.awid;
                    w_addr_d  = axi.awaddr;
                    w_len_d   = axi.awlen;
                    w_size_d  = axi.awsize;
                    w_burst_d = axi.awburst;
                    w_beat_d  = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_gnt) begin
                    if (!w_oor) begin
                        ram_en    = 1'b1;
                        ram_we    = axi.wstrb;
                        ram_addr  = w_addr_q[MEM_AW+1:2];
                        ram_wdata = axi.wdata;
                    end
                    // wlast must coincide exactly with the last counted beat
                    w_err_nx = w_err_q | w_oor | (axi.wlast != (w_beat_q == w_len_q));
                    w_err_d  = w_err_nx;
                    w_beat_d = w_beat_q + 8'd1;
                    w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                    if (axi.wlast) begin
                        bresp_d   = w_err_nx ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= 32'h0;
            r_len_q   <= 8'd0;
            r_size_q  <= 3'd0;
            r_burst_q <= 2'd0;
            r_beat_q  <= 8'd0;
            r_oor_q   <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= 2'b00;
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= 32'h0;
            w_len_q   <= 8'd0;
            w_size_q  <= 3'd0;
            w_burst_q <= 2'd0;
            w_beat_q  <= 8'd0;
            w_err_q   <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_beat_q  <= r_beat_d;
            r_oor_q   <= r_oor_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
            bresp_q   <= bresp_d;
        end
    end

    // Address-channel readies are gated by reset so every output reads 0
    // while reset is held, even though the FSMs already sit in IDLE.
    assign axi.arready = (r_state_q == R_IDLE) && !reset;
    assign axi.awready = (w_state_q == W_IDLE) && !reset;
    assign axi.rvalid  = (r_state_q == R_DATA);
    assign axi.rlast   = (r_state_q == R_DATA) && r_last;
    assign axi.rid     = r_id_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.wready  = w_gnt;
    assign axi.bvalid  = (w_state_q == W_RESP);
    assign axi.bid     = w_id_q;
    assign axi.bresp   = bresp_q;

    // AXI3 write interleaving is not supported, so the W-channel ID is unused.
    logic unused_wid;
    assign unused_wid = ^axi.wid;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural single-port SRAM model.
// Inputs are driven 1 time unit after the rising edge, outputs sampled 4 units after it.
module tb_axi_sram_slave;
    logic        aclk;
    logic        reset;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    axi_sram_slave_if #(.ID_W(4)) axi ();

    axi_sram_slave #(.MEM_AW(16), .ID_W(4)) dut (
        .aclk      (aclk),
        .reset     (reset),
        .axi       (axi),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int en_cnt = 0;
    int ar_cyc, ar_wait, rd_lat, rd_cnt;
    logic [31:0] rd_dat [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id;
    logic [3:0]  wstrb_v [16];
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic [15:0] rd_log [$];

    // SRAM model: unwritten words read back as a known address pattern
    logic [31:0] mem [0:65535];
    bit          mem_vld [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr;
    logic [31:0] pl_dat;
    logic [31:0] cur;

    function automatic logic [31:0] model_rd(input logic [15:0] a);
        return mem_vld[a] ? mem[a] : (32'hA500_0000 | {16'h0, a});
    endfunction

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (ram_en) en_cnt <= en_cnt + 1;
        if (pl_en) begin
            mem[pl_addr]     <= pl_dat;
            mem_vld[pl_addr] <= 1'b1;
        end else if (ram_en) begin
            cur = model_rd(ram_addr);
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) cur[8*b +: 8] = ram_wdata[8*b +: 8];
            if (ram_we != 4'h0) begin
                mem[ram_addr]     <= cur;
                mem_vld[ram_addr] <= 1'b1;
            end else begin
                rd_log.push_back(ram_addr);
            end
            ram_rdata <= model_rd(ram_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        bit ok = 0;
        int w = 0;
        axi.arid = id; axi.araddr = addr; axi.arlen = len;
        axi.arsize = 3'd2; axi.arburst = 2'b01; axi.arvalid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            #3;
            if (axi.arready) begin ok = 1; ar_cyc = cyc; end
            else w++;
            step();
        end
        axi.arvalid = 1'b0;
        ar_wait = w;
        if (!ok) check("ar_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        bit ok = 0;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len;
        axi.awsize = 3'd2; axi.awburst = 2'b01; axi.awvalid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            #3;
            if (axi.awready) ok = 1;
            step();
        end
        axi.awvalid = 1'b0;
        if (!ok) check("aw_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_burst(input int n, input bit toggle);
        bit pend = 0;
        bit seen = 0;
        logic [31:0] pd;
        logic [1:0]  pr;
        logic        pl;
        rd_cnt = 0;
        axi.rready = 1'b1;
        for (int t = 0; t < 200 && rd_cnt < n; t++) begin
            #3;
            if (pend) begin
                check("r_hold", {axi.rvalid, axi.rlast, axi.rresp, axi.rdata[27:0]},
                      {1'b1, pl, pr, pd[27:0]});
                check("r_hold_hi", {28'h0, axi.rdata[31:28]}, {28'h0, pd[31:28]});
            end
            pend = 0;
            if (axi.rvalid && !seen) begin seen = 1; rd_lat = cyc - ar_cyc; end
            if (axi.rvalid && axi.rready) begin
                rd_dat[rd_cnt] = axi.rdata; rd_resp[rd_cnt] = axi.rresp;
                rd_last[rd_cnt] = axi.rlast; rd_id = axi.rid;
                rd_cnt++;
            end else if (axi.rvalid) begin
                pend = 1; pd = axi.rdata; pr = axi.rresp; pl = axi.rlast;
            end
            step();
            axi.rready = toggle ? !axi.rready : 1'b1;
        end
        axi.rready = 1'b0;
        check("r_beats", rd_cnt, n);
    endtask

    task automatic write_burst(input int n, input logic [31:0] base);
        bit ok;
        bit got = 0;
        for (int i = 0; i < n; i++) begin
            axi.wvalid = 1'b1; axi.wdata = base + i; axi.wstrb = wstrb_v[i];
            axi.wlast = (i == n - 1); axi.wid = 4'h0;
            ok = 0;
            for (int t = 0; t < 50 && !ok; t++) begin
                #3;
                if (axi.wready) ok = 1;
                step();
            end
            if (!ok) check("w_timeout", 32'd0, 32'd1);
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        axi.bready = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            #3;
            if (axi.bvalid) begin got = 1; b_resp = axi.bresp; b_id = axi.bid; end
            step();
        end
        axi.bready = 1'b0;
        if (!got) check("b_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int e0;
        reset = 1'b1;
        axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
        axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
        axi.wvalid = 0; axi.wid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0;
        axi.rready = 0; axi.bready = 0;
        for (int i = 0; i < 16; i++) wstrb_v[i] = 4'hF;
        step();
        pl_en = 1'b1; pl_addr = 16'h0040; pl_dat = 32'hDEAD_BEEF;
        step();
        pl_en = 1'b0;
        step();
        #3;
        // reset state: every output 0
        check("rst_arready", axi.arready, 0);
        check("rst_awready", axi.awready, 0);
        check("rst_rvalid",  axi.rvalid, 0);
        check("rst_wready",  axi.wready, 0);
        check("rst_bvalid",  axi.bvalid, 0);
        check("rst_r_fields", {axi.rdata[15:0], axi.rid, axi.rresp, axi.rlast}, 0);
        check("rst_b_fields", {axi.bid, axi.bresp}, 0);
        check("rst_ram", {ram_en, ram_we, ram_addr}, 0);
        step();
        reset = 1'b0;
        #3;
        check("idle_arready", axi.arready, 1);
        check("idle_awready", axi.awready, 1);
        step();

        // single read
        do_ar(4'h5, 32'h100, 8'd0);
        read_burst(1, 0);
        check("t1_lat",  rd_lat, 3);
        check("t1_data", rd_dat[0], 32'hDEAD_BEEF);
        check("t1_resp", rd_resp[0], 2'b00);
        check("t1_last", rd_last[0], 1);
        check("t1_id",   rd_id, 4'h5);

        // INCR read with rready toggling
        rd_log.delete();
        do_ar(4'h2, 32'h200, 8'd3);
        read_burst(4, 1);
        check("t2_nreads", rd_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rd_log.size()) check($sformatf("t2_addr%0d", i), rd_log[i], 16'h80 + i);
            check($sformatf("t2_data%0d", i), rd_dat[i], 32'hA500_0080 + i);
            check($sformatf("t2_last%0d", i), rd_last[i], (i == 3));
        end

        // write burst with partial strobe on beat 1, then read back
        wstrb_v[1] = 4'b0011;
        do_aw(4'h9, 32'h300, 8'd3);
        write_burst(4, 32'hCAFE_0000);
        wstrb_v[1] = 4'hF;
        check("t3_bresp", b_resp, 2'b00);
        check("t3_bid", b_id, 4'h9);
        do_ar(4'h1, 32'h300, 8'd3);
        read_burst(4, 0);
        check("t3_rb0", rd_dat[0], 32'hCAFE_0000);
        check("t3_rb1", rd_dat[1], 32'hA500_0001);
        check("t3_rb2", rd_dat[2], 32'hCAFE_0002);
        check("t3_rb3", rd_dat[3], 32'hCAFE_0003);

        // concurrent AR + AW in the same cycle
        axi.arid = 4'h3; axi.araddr = 32'h400; axi.arlen = 8'd3; axi.arsize = 3'd2; axi.arburst = 2'b01;
        axi.awid = 4'h4; axi.awaddr = 32'h800; axi.awlen = 8'd3; axi.awsize = 3'd2; axi.awburst = 2'b01;
        axi.arvalid = 1'b1; axi.awvalid = 1'b1;
        #3;
        check("t4_both_rdy", {axi.arready, axi.awready}, 2'b11);
        ar_cyc = cyc;
        step();
        axi.arvalid = 1'b0; axi.awvalid = 1'b0;
        fork
            read_burst(4, 0);
            write_burst(4, 32'hBEEF_0000);
        join
        check("t4_lat", rd_lat, 7);
        check("t4_bresp", b_resp, 2'b00);
        check("t4_bid", b_id, 4'h4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_rd%0d", i), rd_dat[i], 32'hA500_0100 + i);
            check($sformatf("t4_mem%0d", i), model_rd(16'h200 + i[15:0]), 32'hBEEF_0000 + i);
        end

        // out-of-range read
        e0 = en_cnt;
        do_ar(4'h6, 32'hFFFF_0000, 8'd0);
        read_burst(1, 0);
        check("t5_resp", rd_resp[0], 2'b10);
        check("t5_data", rd_data_or0(rd_dat[0]), 32'h0);
        check("t5_ram_en", en_cnt - e0, 0);

        // early wlast
        do_aw(4'h7, 32'h900, 8'd1);
        write_burst(1, 32'h1234_5678);
        check("t6_bresp", b_resp, 2'b10);

        // reset during R_DATA of beat 2
        do_ar(4'h8, 32'h200, 8'd3);
        read_burst(2, 0);
        e0 = 0;
        for (int t = 0; t < 20 && !axi.rvalid; t++) begin
            #3;
            if (!axi.rvalid) step();
        end
        check("t7_in_beat2", axi.rvalid, 1);
        step();
        reset = 1'b1;
        step();
        #3;
        check("t7_rvalid", axi.rvalid, 0);
        check("t7_r_fields", {axi.rdata[15:0], axi.rid, axi.rresp, axi.rlast}, 0);
        check("t7_bvalid", axi.bvalid, 0);
        check("t7_ram_en", ram_en, 0);
        step();
        reset = 1'b0;
        do_ar(4'hA, 32'h100, 8'd0);
        check("t7_ar_wait", ar_wait, 0);
        read_burst(1, 0);
        check("t7_data", rd_dat[0], 32'hDEAD_BEEF);
        check("t7_id", rd_id, 4'hA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic [31:0] rd_data_or0(input logic [31:0] d);
        return d;
    endfunction
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder that serves the CPU-side AXI master's read and write bursts from a single-port synchronous SRAM.
- Used as the memory end of the CPU's AXI interface in simulation and in SoC bring-up.
- Read and write channels run independently, each with one outstanding transaction.
- The two channels share the SRAM port under a fixed-priority arbiter.

Parameters:
- MEM_AW, 16, word-address width of the SRAM; the SRAM holds 2^MEM_AW 32-bit words.
- ID_W, 4, width of all AXI ID fields.

Ports:
- aclk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- arid  in  ID_W  read ID
- araddr  in  32  read byte address
- arlen  in  8  beats minus 1; only 0..15 are legal
- arsize  in  3  bytes per beat, log2; 0..2
- arburst  in  2  01 = INCR, 00 = FIXED; any other value is treated as INCR
- arvalid  in  1
- arready  out  1
- rid  out  ID_W
- rdata  out  32
- rresp  out  2
- rlast  out  1
- rvalid  out  1
- rready  in  1
- awid, awaddr, awlen, awsize, awburst  in  ID_W/32/8/3/2  same meanings as the AR channel
- awvalid  in  1
- awready  out  1
- wid  in  ID_W  ignored
- wdata  in  32
- wstrb  in  4
- wlast  in  1
- wvalid  in  1
- wready  out  1
- bid  out  ID_W
- bresp  out  2
- bvalid  out  1
- bready  in  1
- ram_en  out  1  SRAM access enable
- ram_we  out  4  SRAM byte write enables
- ram_addr  out  MEM_AW  SRAM word address
- ram_wdata  out  32  SRAM write data
- ram_rdata  in  32  SRAM read data, valid the cycle after an enabled read

Behaviour:
- Reset: every output is 0. Both FSMs go to IDLE; beat counters go to 0.
- Read FSM states: R_IDLE, R_REQ, R_WAIT, R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch id/addr/len/size/burst, clear beat count, go to R_REQ.
  - R_REQ: request the SRAM port. When granted, drive ram_en=1, ram_we=0, ram_addr=addr[MEM_AW+1:2], then go to R_WAIT.
  - R_WAIT: capture ram_rdata into the rdata register, then go to R_DATA.
  - R_DATA: rvalid=1; rid = latched id; rlast = (beat==len).
  - rdata, rresp, rlast are held stable while rvalid && !rready.
  - On R handshake with rlast: go to R_IDLE.
  - On R handshake without rlast: beat+1, advance the address, go to R_REQ.
  - Minimum read latency is 3 cycles from the AR handshake to the first rvalid.
- Address advance:
  - INCR: addr += 1<<size, with the increment computed on the full 32 bits.
  - FIXED: addr unchanged.
- Range check:
  - A beat is out of range if addr[31:MEM_AW+2] != 0.
  - Out-of-range read beat: ram_en=0, rdata=0, rresp=2'b10 (SLVERR), but the read still passes through R_WAIT.
  - In-range read beat: rresp=2'b00.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch the fields, clear beat count and the error flag, go to W_DATA.
  - W_DATA: wready=1 only when the write side holds the grant this cycle.
  - On each W handshake: ram_en=1 and ram_we=wstrb if in range; otherwise ram_we=0 and set the error flag. Then beat+1 and advance the address.
  - If wlast && beat!=len, or !wlast && beat==len: set the error flag. The burst always terminates on the wlast handshake.
  - After wlast: go to W_RESP with bvalid=1, bid = latched id, bresp = error ? 2'b10 : 2'b00. Hold until bready, then go to W_IDLE.
- Arbitration:
  - Write wins when R_REQ and a W_DATA beat with wvalid=1 coincide; the read stalls one cycle.
  - Write with wvalid=0 does not claim the port.
  - A read request is never starved for more than one cycle per write beat.
- AR and AW handshakes in the same cycle are both accepted.
- Reset asserted mid-burst: abort immediately, all outputs return to 0 on the next edge, and no partial response is sent.

Test Plan:
- Single read: araddr=0x100, arlen=0, arsize=2, with ram word 0x40 = 0xDEADBEEF -> one beat: rdata=0xDEADBEEF, rresp=00, rlast=1, rid=arid, first rvalid 3 cycles after the AR handshake.
- INCR read: araddr=0x200, arlen=3, rready toggling 1/0 -> ram_addr sequence 0x80, 0x81, 0x82, 0x83; rlast only on beat 3; data held stable while rready=0.
- Write burst then readback: awaddr=0x300, awlen=3, wstrb=4'b0011 on beat 1 -> bresp=00; readback shows only the low half of word 0xC1 changed.
- Concurrent traffic: AR and AW handshake in the same cycle, with a 4-beat read and a 4-beat write on disjoint addresses -> writes take the port on conflicts, both complete correctly, no lost beat.
- Error cases:
  - araddr=0xFFFF_0000 -> rresp=10, rdata=0, ram_en stays 0.
  - awlen=1 but wlast sent on beat 0 -> bresp=10.
- Reset mid-read: reset asserted during R_DATA of beat 2 -> rvalid=0 next cycle; a new AR is accepted immediately after reset deasserts.
